system_led_sequencer: RTL and testbench

//  Autonomous sequencer for the 8-bit LED PIO. Holds a table of up to DEPTH LED patterns,

---
 rtl/system_led_sequencer.sv | 162 ++++++++++++++++
 tb/tb_system_led_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/system_led_sequencer.sv
// LED pattern sequencer: an Avalon-MM slave holds the pattern table.
// An Avalon-MM master writes each step into the LED PIO s1 slave.
module system_led_sequencer #(
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = IW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    state_t              state;
    logic                en;
    logic                oneshot;
    logic                done;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic [LW-1:0]       length;
    logic [IW-1:0]       index;
    logic [DATA_W-1:0]   table_q [DEPTH];
    logic [DATA_W-1:0]   pat_q;

    logic                wr;
    logic                ctrl_wr;
    logic                tbl_hit;
    logic [IW-1:0]       tbl_idx;
    logic [PERIOD_W-1:0] period_eff;
    logic [LW-1:0]       len_eff;
    logic                last;
    logic [IW-1:0]       nxt_idx;
    logic                advance;
    logic                running;

    assign wr         = chipselect & ~write_n;
    assign ctrl_wr    = wr && (address == 4'd0);
    assign tbl_hit    = address[3] && ({1'b0, address[2:0]} < 4'(DEPTH));
    assign tbl_idx    = address[IW-1:0];
    assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
    assign len_eff    = (length == '0) ? LW'(1) : length;
    assign last       = ({1'b0, index} >= (len_eff - LW'(1)));
    assign nxt_idx    = last ? '0 : index + IW'(1);
    assign running    = (state == LOAD) || (state == WAIT);

    // Step boundary: leaving LOAD when the period is a single cycle, or end of WAIT.
    assign advance = ((state == LOAD) && (period_eff <= PERIOD_W'(1))) ||
                     ((state == WAIT) && (cnt == PERIOD_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            en      <= 1'b0;
            oneshot <= 1'b0;
            done    <= 1'b0;
            period  <= '0;
            cnt     <= '0;
            length  <= '0;
            index   <= '0;
            pat_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            if (wr && (address == 4'd1)) begin
                period <= writedata[PERIOD_W-1:0];
            end
            if (wr && (address == 4'd2)) begin
                if (writedata == 32'd0) begin
                    length <= LW'(1);
                end else if (writedata > 32'(DEPTH)) begin
                    length <= LW'(DEPTH);
                end else begin
                    length <= writedata[LW-1:0];
                end
            end
            if (wr && tbl_hit) begin
                table_q[tbl_idx] <= writedata[DATA_W-1:0];
            end

            if (ctrl_wr) begin
                en      <= writedata[0];
                oneshot <= writedata[1];
                done    <= 1'b0;
                index   <= '0;
                cnt     <= '0;
                if (writedata[0]) begin
                    state <= LOAD;
                    pat_q <= table_q[0];
                end else begin
                    state <= IDLE;
                end
            end else begin
                unique case (state)
                    IDLE: ;
                    LOAD: begin
                        cnt <= period_eff - PERIOD_W'(1);
                        if (!advance) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: cnt <= cnt - PERIOD_W'(1);
                    DONE: begin
                        done    <= 1'b1;
                        en      <= 1'b0;
                        oneshot <= 1'b0;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
                if (advance) begin
                    if (last && oneshot) begin
                        state <= DONE;
                        index <= '0;
                    end else begin
                        state <= LOAD;
                        index <= nxt_idx;
                        pat_q <= table_q[nxt_idx];
                    end
                end
            end
        end
    end

    // Reset gates the strobe so a mid-LOAD reset never reaches the PIO.
    assign pio_chipselect = (state == LOAD) & ~reset;
    assign pio_write_n    = ~pio_chipselect;
    assign pio_address    = 2'd0;
    assign pio_writedata  = 32'(pat_q);
    assign busy           = running & ~reset;

    always_comb begin
        readdata = '0;
        if (address[3]) begin
            if (tbl_hit) begin
                readdata = 32'(table_q[tbl_idx]);
            end
        end else begin
            case (address[2:0])
                3'd0: readdata = {30'd0, oneshot, en};
                3'd1: readdata = 32'(period);
                3'd2: readdata = 32'(length);
                3'd3: readdata = {25'd0, 3'(index), 2'd0, done, running};
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_system_led_sequencer.sv
// Bench for system_led_sequencer: directed scenarios plus random bus traffic
// compared cycle by cycle against a countdown-based reference model.
module tb_system_led_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        busy;

    system_led_sequencer dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .pio_address(pio_address),
        .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n),
        .pio_writedata(pio_writedata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: register file plus a "cycles until next strobe" counter.
    logic        m_en, m_os, m_done, m_run, m_dpend;
    logic [31:0] m_period;
    int          m_len, m_idx, m_wl;
    logic [7:0]  m_pat;
    logic [7:0]  m_tbl [8];

    logic [31:0] obs_rd;
    logic        obs_cs;
    logic [7:0]  strobes [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] r;
        r = '0;
        if (a >= 4'd8) begin
            r = 32'(m_tbl[a - 4'd8]);
        end else if (a == 4'd0) begin
            r = {30'd0, m_os, m_en};
        end else if (a == 4'd1) begin
            r = m_period;
        end else if (a == 4'd2) begin
            r = 32'(m_len);
        end else if (a == 4'd3) begin
            r[0]   = m_run;
            r[1]   = m_done;
            r[6:4] = 3'(m_idx);
        end
        return r;
    endfunction

    task automatic m_clear();
        m_en = 0; m_os = 0; m_done = 0; m_run = 0; m_dpend = 0;
        m_period = 0; m_len = 0; m_idx = 0; m_wl = 0; m_pat = 0;
        for (int i = 0; i < 8; i++) m_tbl[i] = 0;
    endtask

    task automatic m_step();
        bit wr, adv;
        int p, l;
        if (reset) begin
            m_clear();
            return;
        end
        wr = chipselect && !write_n;
        p = (m_period == 0) ? 1 : int'(m_period);
        l = (m_len == 0) ? 1 : m_len;
        if (wr && address == 4'd0) begin
            m_en = writedata[0];
            m_os = writedata[1];
            m_done = 0;
            m_dpend = 0;
            m_idx = 0;
            m_run = writedata[0];
            m_wl = 0;
            if (writedata[0]) m_pat = m_tbl[0];
        end else if (m_dpend) begin
            m_done = 1; m_en = 0; m_os = 0; m_dpend = 0;
        end else if (m_run) begin
            if (m_wl == 0) m_wl = p - 1;
            else m_wl--;
            adv = (m_wl == 0);
            if (adv) begin
                if (m_idx >= l - 1 && m_os) begin
                    m_run = 0; m_dpend = 1; m_idx = 0;
                end else begin
                    m_idx = (m_idx >= l - 1) ? 0 : m_idx + 1;
                    m_pat = m_tbl[m_idx];
                end
            end
        end
        if (wr && address == 4'd1) m_period = writedata;
        if (wr && address == 4'd2)
            m_len = (writedata == 0) ? 1 : (writedata > 8) ? 8 : int'(writedata);
        if (wr && address >= 4'd8) m_tbl[address - 4'd8] = writedata[7:0];
    endtask

    // One bus cycle: drive, compare at negedge, advance model at posedge.
    task automatic cycle(input logic r, input logic cs, input logic wn,
                         input logic [3:0] a, input logic [31:0] d);
        bit s;
        reset = r; chipselect = cs; write_n = wn; address = a; writedata = d;
        @(negedge clk);
        s = !r && m_run && (m_wl == 0);
        obs_rd = readdata;
        obs_cs = pio_chipselect;
        chk("pio_cs", 32'(pio_chipselect), 32'(s));
        chk("pio_wn", 32'(pio_write_n), 32'(!s));
        chk("pio_addr", 32'(pio_address), 32'd0);
        chk("busy", 32'(busy), 32'(!r && m_run));
        if (s) chk("pio_data", pio_writedata, 32'(m_pat));
        if (!r) chk("readdata", readdata, m_read(a));
        if (pio_chipselect) strobes.push_back(pio_writedata[7:0]);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        cycle(1'b0, 1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom);
    endtask

    task automatic chk_seq(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_n"}, 32'(strobes.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < strobes.size(); i++)
            chk(tag, 32'(strobes[i]), 32'(exp[i]));
    endtask

    initial begin
        int sel;
        m_clear();
        reset = 1; chipselect = 0; write_n = 1; address = 0; writedata = 0;
        @(posedge clk); #1;
        cycle(1'b1, 1'b0, 1'b1, 4'd0, 32'd0);

        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            chk("reset_rd", obs_rd, 32'd0);
        end

        wr(4'd8, 32'h01); wr(4'd9, 32'h02); wr(4'd10, 32'h04); wr(4'd11, 32'h08);
        wr(4'd2, 32'd4); wr(4'd1, 32'd5);
        wr(4'd0, 32'd1);
        strobes.delete();
        idle(21);
        chk_seq("loop_seq", '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01});

        wr(4'd0, 32'd3);
        strobes.delete();
        idle(25);
        chk_seq("oneshot_seq", '{8'h01, 8'h02, 8'h04, 8'h08});
        rd(4'd3);
        chk("oneshot_status", obs_rd, 32'h2);
        rd(4'd0);
        chk("oneshot_ctrl", obs_rd, 32'h0);

        wr(4'd1, 32'd0); wr(4'd2, 32'd2); wr(4'd0, 32'd1);
        strobes.delete();
        idle(6);
        chk_seq("p0_seq", '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02});
        wr(4'd1, 32'd1);
        strobes.delete();
        idle(4);
        chk("p1_count", 32'(strobes.size()), 32'd4);
        wr(4'd0, 32'd0);

        wr(4'd1, 32'd5); wr(4'd2, 32'd4); wr(4'd0, 32'd1);
        idle(3);
        wr(4'd0, 32'd0);
        strobes.delete();
        idle(10);
        chk("stop_count", 32'(strobes.size()), 32'd0);
        wr(4'd0, 32'd1);
        idle(7);
        wr(4'd0, 32'd1);
        strobes.delete();
        idle(1);
        chk_seq("restart", '{8'h01});

        wr(4'd1, 32'd0); wr(4'd0, 32'd1);
        idle(3);
        cycle(1'b1, 1'b0, 1'b1, 4'd0, 32'd0);
        chk("rst_cs", 32'(obs_cs), 32'd0);
        strobes.delete();
        idle(3);
        chk("post_rst_cnt", 32'(strobes.size()), 32'd0);
        wr(4'd2, 32'd9);
        rd(4'd2);
        chk("len_clamp", obs_rd, 32'd8);
        rd(4'd8);
        chk("tbl_cleared", obs_rd, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 1)
                cycle(1'b1, 1'b0, 1'b1, 4'd0, 32'd0);
            else if (sel < 5)
                wr(4'd0, 32'($urandom_range(0, 3)));
            else if (sel < 9)
                wr(4'd1, 32'($urandom_range(0, 6)));
            else if (sel < 13)
                wr(4'd2, 32'($urandom_range(0, 10)));
            else if (sel < 22)
                wr(4'($urandom_range(8, 15)), $urandom);
            else if (sel < 25)
                wr(4'($urandom_range(4, 7)), $urandom);
            else
                idle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
